// File: rtl/rng_sop_buffer.sv
// rng_sop_buffer: pulls 128-bit RNG blocks, splits them into 32-bit words and
// serves them from a word FIFO through a valid/pop interface.
// Optional feature macro: RNG_SOP_REPEAT_CHK_EN (drops and flags repeated blocks).
module rng_sop_buffer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              rng_clk,
  input  logic              rst_n,
  input  logic              sw_flush,
  input  logic [127:0]      sop_data,
  input  logic              sop_valid,
  output logic              rd_sop,
  output logic [31:0]       rnd_data,
  output logic              rnd_rdy,
  input  logic              rnd_rd,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              rep_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACK  = 3'd1;
`ifdef RNG_SOP_REPEAT_CHK_EN
  localparam logic [2:0] CHK  = 3'd2;
`endif
  localparam logic [2:0] WR0  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
  localparam logic [2:0] WR2  = 3'd5;
  localparam logic [2:0] WR3  = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             rd_sop_q;
  logic [127:0]     staging;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             wr_en_c;
  logic [31:0]      wr_word_c;
  logic             rd_en_c;
  logic             space_ok_c;

`ifdef RNG_SOP_REPEAT_CHK_EN
  logic [127:0]     prev_blk;
  logic             prev_vld;
  logic             rep_err_q;
  logic             blk_dup_c;

  assign blk_dup_c = prev_vld && (staging == prev_blk);
`endif

  // A whole block must fit before it is acknowledged
  assign space_ok_c = (level <= LVL_W'(DEPTH - 4));
  assign rd_en_c    = rnd_rd && (level != '0) && !sw_flush;

  // Next-state and word-write decode
  always_comb begin
    state_nxt = state;
    wr_en_c   = 1'b0;
    wr_word_c = '0;
    case (state)
      IDLE: if (sop_valid && space_ok_c) state_nxt = ACK;
`ifdef RNG_SOP_REPEAT_CHK_EN
      ACK:  state_nxt = CHK;
      CHK:  state_nxt = blk_dup_c ? IDLE : WR0;
`else
      ACK:  state_nxt = WR0;
`endif
      WR0: begin
        wr_en_c   = 1'b1;
        wr_word_c = staging[31:0];
        state_nxt = WR1;
      end
      WR1: begin
        wr_en_c   = 1'b1;
        wr_word_c = staging[63:32];
        state_nxt = WR2;
      end
      WR2: begin
        wr_en_c   = 1'b1;
        wr_word_c = staging[95:64];
        state_nxt = WR3;
      end
      WR3: begin
        wr_en_c   = 1'b1;
        wr_word_c = staging[127:96];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (sw_flush) begin
      state_nxt = IDLE;
      wr_en_c   = 1'b0;
    end
  end

  // State register; acknowledge is registered from the entry into ACK
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_sop_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_sop_q <= (state_nxt == ACK);
    end
  end

  // Staging register captures the block while it is acknowledged
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (sw_flush) begin
      staging <= '0;
    end else if (state == ACK) begin
      staging <= sop_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (sw_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Word storage; popped entries keep stale data, hidden by output gating
  always_ff @(posedge rng_clk) begin
    if (wr_en_c) mem[wr_ptr] <= wr_word_c;
  end

`ifdef RNG_SOP_REPEAT_CHK_EN
  // Repeated-block detection against the last accepted block
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_blk  <= '0;
      prev_vld  <= 1'b0;
      rep_err_q <= 1'b0;
    end else if (sw_flush) begin
      prev_blk  <= '0;
      prev_vld  <= 1'b0;
      rep_err_q <= 1'b0;
    end else if (state == CHK) begin
      if (blk_dup_c) begin
        rep_err_q <= 1'b1;
      end else begin
        prev_blk <= staging;
        prev_vld <= 1'b1;
      end
    end
  end

  assign rep_err = rep_err_q;
`else
  assign rep_err = 1'b0;
`endif

  assign rd_sop     = rd_sop_q & ~sw_flush;
  assign rnd_rdy    = (level != '0);
  assign rnd_data   = rnd_rdy ? mem[rd_ptr] : 32'h0;
  assign fifo_level = level;

endmodule

// File: tb/tb_rng_sop_buffer.sv
// Directed testbench for rng_sop_buffer (DEPTH=16).
module tb_rng_sop_buffer;

  localparam int unsigned LVL_W = 5;
`ifdef RNG_SOP_REPEAT_CHK_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              rng_clk = 1'b0;
  logic              rst_n;
  logic              sw_flush;
  logic [127:0]      sop_data;
  logic              sop_valid;
  logic              rd_sop;
  logic [31:0]       rnd_data;
  logic              rnd_rdy;
  logic              rnd_rd;
  logic [LVL_W-1:0]  fifo_level;
  logic              rep_err;

  int checks = 0;
  int errors = 0;
  int sop_cnt = 0;
  int gap_viol = 0;
  int lvl_viol = 0;
  int cyc = 0;
  int last_sop = -100;

  rng_sop_buffer #(.DEPTH(16)) dut (
    .rng_clk    (rng_clk),
    .rst_n      (rst_n),
    .sw_flush   (sw_flush),
    .sop_data   (sop_data),
    .sop_valid  (sop_valid),
    .rd_sop     (rd_sop),
    .rnd_data   (rnd_data),
    .rnd_rdy    (rnd_rdy),
    .rnd_rd     (rnd_rd),
    .fifo_level (fifo_level),
    .rep_err    (rep_err)
  );

  always #5 rng_clk = ~rng_clk;

  // Acknowledge pulse counting, spacing and level bound
  always @(posedge rng_clk) begin
    cyc <= cyc + 1;
    if (rd_sop) begin
      sop_cnt  <= sop_cnt + 1;
      last_sop <= cyc;
      if (cyc - last_sop < 5) gap_viol <= gap_viol + 1;
    end
    if (fifo_level > 5'd16) lvl_viol <= lvl_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge rng_clk);
  endtask

  task automatic wait_sop(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (rd_sop) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, rnd_data, base + 32'(i));
      rnd_rd = 1'b1;
      tick();
    end
    rnd_rd = 1'b0;
  endtask

  function automatic logic [127:0] blk(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    bit found;
    int cnt0;
    int nexp;
    int nblk;
    bit pend;
    int npop;

    rst_n     = 1'b0;
    sw_flush  = 1'b0;
    sop_data  = '0;
    sop_valid = 1'b0;
    rnd_rd    = 1'b0;
    repeat (3) tick();
    chk("rst_rd_sop", 32'(rd_sop), 32'd0);
    chk("rst_rdy", 32'(rnd_rdy), 32'd0);
    chk("rst_data", rnd_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_rep_err", 32'(rep_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single block, words popped A..D
    sop_data  = 128'h0000000D_0000000C_0000000B_0000000A;
    sop_valid = 1'b1;
    wait_sop(10, found);
    chk("t1_ack", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (5 + LAT) tick();
    chk("t1_level4", 32'(fifo_level), 32'd4);
    chk("t1_rdy", 32'(rnd_rdy), 32'd1);
    chk("t1_one_ack", 32'(sop_cnt), 32'd1);
    pop_check("t1_word", 32'h0000000A, 4);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    chk("t1_empty_data", rnd_data, 32'd0);
    chk("t1_empty_rdy", 32'(rnd_rdy), 32'd0);

    // 2: fill to DEPTH, fetch only resumes with four free words
    cnt0      = sop_cnt;
    sop_data  = blk(32'h2000_0000);
    sop_valid = 1'b1;
    repeat (40) tick();
    chk("t2_acks", 32'(sop_cnt - cnt0), 32'd4);
    chk("t2_full", 32'(fifo_level), 32'd16);
    chk("t2_no_ack", 32'(rd_sop), 32'd0);
    rnd_rd = 1'b1;
    tick();
    rnd_rd = 1'b0;
    repeat (10) tick();
    chk("t2_level15", 32'(fifo_level), 32'd15);
    chk("t2_still4", 32'(sop_cnt - cnt0), 32'd4);
    rnd_rd = 1'b1;
    repeat (3) tick();
    rnd_rd = 1'b0;
    chk("t2_level12", 32'(fifo_level), 32'd12);
    wait_sop(10, found);
    chk("t2_resume", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (5 + LAT) tick();
    chk("t2_refull", 32'(fifo_level), 32'd16);
    npop = 0;
    rnd_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!rnd_rdy) break;
      chk("t2_drain", rnd_data, 32'h2000_0000 + 32'(i % 4));
      npop++;
      tick();
    end
    rnd_rd = 1'b0;
    chk("t2_drain_cnt", 32'(npop), 32'd16);

    // 3: streaming with continuous pops, >= 3*DEPTH words
    nexp      = 0;
    nblk      = 0;
    pend      = 1'b0;
    sop_data  = blk(32'h3000_0000);
    sop_valid = 1'b1;
    rnd_rd    = 1'b1;
    for (int c = 0; c < 600 && nexp < 56; c++) begin
      tick();
      if (pend) begin
        nblk++;
        sop_data = blk(32'h3000_0000 + 32'(4 * nblk));
        pend = 1'b0;
      end
      if (rd_sop) pend = 1'b1;
      if (rnd_rdy) begin
        chk("t3_word", rnd_data, 32'h3000_0000 + 32'(nexp));
        nexp++;
      end
    end
    chk("t3_count", 32'(nexp >= 56), 32'd1);
    sop_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rnd_rdy) begin
        chk("t3_tail", rnd_data, 32'h3000_0000 + 32'(nexp));
        nexp++;
      end
    end
    rnd_rd = 1'b0;
    chk("t3_level0", 32'(fifo_level), 32'd0);
    chk("t3_words_blk", 32'(nexp % 4), 32'd0);

    // 4: flush during WR2 abandons the partial block
    sop_data  = blk(32'h4000_0000);
    sop_valid = 1'b1;
    wait_sop(10, found);
    chk("t4_ack", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (3 + LAT) tick();
    chk("t4_partial", 32'(fifo_level), 32'd2);
    sw_flush = 1'b1;
    tick();
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_rdy", 32'(rnd_rdy), 32'd0);
    chk("t4_data", rnd_data, 32'd0);
    chk("t4_rd_sop", 32'(rd_sop), 32'd0);
    sw_flush = 1'b0;
    repeat (6) tick();
    chk("t4_no_partial", 32'(fifo_level), 32'd0);
    sop_data  = blk(32'h5000_0000);
    sop_valid = 1'b1;
    wait_sop(10, found);
    chk("t4_next_ack", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (5 + LAT) tick();
    chk("t4_next_level", 32'(fifo_level), 32'd4);
    pop_check("t4_word", 32'h5000_0000, 4);

    // 5: pops while empty are ignored
    rnd_rd = 1'b1;
    repeat (3) tick();
    rnd_rd = 1'b0;
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_rdy", 32'(rnd_rdy), 32'd0);
    chk("t5_data", rnd_data, 32'd0);
    sop_data  = blk(32'h6000_0000);
    sop_valid = 1'b1;
    wait_sop(10, found);
    chk("t5_ack", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (5 + LAT) tick();
    chk("t5_level4", 32'(fifo_level), 32'd4);
    pop_check("t5_word", 32'h6000_0000, 4);

    // 6: same block delivered twice
    cnt0      = sop_cnt;
    sop_data  = blk(32'h7000_0000);
    sop_valid = 1'b1;
    wait_sop(10, found);
    chk("t6_ack1", 32'(found), 32'd1);
    wait_sop(20, found);
    chk("t6_ack2", 32'(found), 32'd1);
    sop_valid = 1'b0;
    repeat (5 + LAT) tick();
    chk("t6_acks", 32'(sop_cnt - cnt0), 32'd2);
`ifdef RNG_SOP_REPEAT_CHK_EN
    chk("t6_level", 32'(fifo_level), 32'd4);
    chk("t6_rep_err", 32'(rep_err), 32'd1);
    pop_check("t6_word", 32'h7000_0000, 4);
    chk("t6_rep_hold", 32'(rep_err), 32'd1);
    sw_flush = 1'b1;
    tick();
    sw_flush = 1'b0;
    chk("t6_rep_clr", 32'(rep_err), 32'd0);
`else
    chk("t6_level", 32'(fifo_level), 32'd8);
    chk("t6_rep_err", 32'(rep_err), 32'd0);
    pop_check("t6_word_a", 32'h7000_0000, 4);
    pop_check("t6_word_b", 32'h7000_0000, 4);
    chk("t6_level0", 32'(fifo_level), 32'd0);
`endif

    tick();
    chk("ack_spacing", 32'(gap_viol), 32'd0);
    chk("level_bound", 32'(lvl_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
